// File: rtl/paritygen.sv
// paritygen -- serial odd-parity generator.
//
// Captures an N-bit word on an accepted start and folds it into a parity bit
// one bit per clock, LSB first. The result is ~^b: 1 when the word holds an
// even number of ones.
//
// Ports:
//   clock   in   1   rising-edge clock for all state
//   reset   in   1   synchronous, active-high reset
//   start   in   1   request pulse; b is captured on the accepting edge
//   b       in   N   data word
//   parity  out  1   registered parity of the last completed word
//   ready   out  1   registered; high while parity is valid for the latest word
module paritygen #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] b,
    output logic         parity,
    output logic         ready
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          acc_q,   acc_d;
    logic          parity_q, parity_d;
    logic          ready_q,  ready_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            parity_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            parity_q <= parity_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        parity_d = parity_q;
        ready_d  = ready_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shreg_d = b;
                    // Seeding with 1 makes the fold produce odd parity (~^b).
                    acc_d   = 1'b1;
                    cnt_d   = CW'(N);
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // start is deliberately ignored here.
                acc_d   = acc_q ^ shreg_q[0];
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last bit: publish the folded value directly rather than
                    // waiting a cycle for acc_q to settle.
                    parity_d = acc_q ^ shreg_q[0];
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign parity = parity_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_paritygen.sv
module tb_paritygen;

    localparam int N = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] b     = '0;
    logic         parity, ready;

    logic         start1 = 1'b0;
    logic [0:0]   b1     = '0;
    logic         parity1, ready1;

    int   tests = 0;
    int   fails = 0;
    logic exp_par;       // parity value the N=32 DUT should currently show

    paritygen #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .b     (b),
        .parity(parity),
        .ready (ready)
    );

    paritygen #(.N(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .start (start1),
        .b     (b1),
        .parity(parity1),
        .ready (ready1)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One full operation on the N=32 DUT. b is scrambled right after the
    // accepting edge; if inj >= 1, a start with b=3 is pulsed before BUSY edge inj.
    task automatic run(input logic [N-1:0] w, input logic exp, input int inj);
        start = 1'b1;
        b     = w;
        tick();
        start = 1'b0;
        b     = ~w;
        check("ready_clr_on_accept", ready, 1'b0);
        check("parity_hold_accept", parity, exp_par);
        for (int i = 1; i < N; i++) begin
            if (i == inj) begin
                start = 1'b1;
                b     = 32'h3;
            end
            tick();
            start = 1'b0;
            check("ready_low_busy", ready, 1'b0);
            check("parity_hold_busy", parity, exp_par);
        end
        tick();
        check("ready_at_N", ready, 1'b1);
        check("parity_result", parity, exp);
        exp_par = exp;
        tick();
        check("ready_hold_done", ready, 1'b1);
        check("parity_hold_done", parity, exp);
    endtask

    initial begin
        logic [N-1:0] w;
        exp_par = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ready", ready, 1'b0);
        check("rst_parity", parity, 1'b0);
        check("rst_ready1", ready1, 1'b0);
        check("rst_parity1", parity1, 1'b0);
        reset = 1'b0;
        tick();
        check("idle_ready", ready, 1'b0);

        // Directed words
        run(32'h0000_0000, 1'b1, -1);
        run(32'hFFFF_FFFF, 1'b1, -1);
        run(32'h0000_0001, 1'b0, -1);
        run(32'h0000_0007, 1'b0, -1);
        run(32'h8000_0001, 1'b1, -1);
        run(32'h0001_0000, 1'b0, -1);

        // Ten random words, b scrambled after capture
        for (int k = 0; k < 10; k++) begin
            w = $urandom();
            run(w, ~^w, -1);
        end

        // Start during BUSY is ignored: b=1 -> parity 0, not that of 3
        run(32'h0000_0000, 1'b1, -1);
        run(32'h0000_0001, 1'b0, 10);

        // Reset mid-operation, after parity was left at 1
        run(32'h0000_0000, 1'b1, -1);
        start = 1'b1;
        b     = 32'h0000_0007;
        tick();
        start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", ready, 1'b0);
        check("abort_parity", parity, 1'b0);
        exp_par = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("abort_no_ready", ready, 1'b0);
        end
        run(32'h0000_0003, 1'b1, -1);

        // Start held high: restart on the edge after DONE, ready high one cycle
        start = 1'b1;
        b     = 32'h0000_0001;
        tick();
        for (int i = 1; i < N; i++) begin
            tick();
            check("held_ready_low", ready, 1'b0);
        end
        tick();
        check("held_ready_1", ready, 1'b1);
        check("held_parity_1", parity, 1'b0);
        tick();
        check("held_restart_clr", ready, 1'b0);
        check("held_parity_keep", parity, 1'b0);
        start = 1'b0;
        for (int i = 1; i < N; i++) tick();
        check("held2_ready_low", ready, 1'b0);
        tick();
        check("held2_ready_1", ready, 1'b1);
        check("held2_parity", parity, 1'b0);

        // N=1 instance
        start1 = 1'b1;
        b1     = 1'b1;
        tick();
        start1 = 1'b0;
        b1     = 1'b0;
        check("n1_busy_ready", ready1, 1'b0);
        tick();
        check("n1_ready_b1", ready1, 1'b1);
        check("n1_parity_b1", parity1, 1'b0);
        start1 = 1'b1;
        b1     = 1'b0;
        tick();
        start1 = 1'b0;
        b1     = 1'b1;
        check("n1_accept_clr", ready1, 1'b0);
        check("n1_parity_keep", parity1, 1'b0);
        tick();
        check("n1_ready_b0", ready1, 1'b1);
        check("n1_parity_b0", parity1, 1'b1);
        tick();
        check("n1_hold_ready", ready1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
